// File: rtl/elevator_state_sequencer_if.sv
// Signal bundle between the elevator state-change logic (master) and the
// registered state stage (slave).
interface elevator_state_sequencer_if;
    logic       x;
    logic [3:0] floor_key;
    logic [1:0] e;
    logic [2:0] c;
    logic [1:0] u;
    logic [1:0] l;
    logic       motor_up;
    logic       motor_down;
    logic       door_open;

    modport master (
        output x, floor_key,
        input  e, c, u, l, motor_up, motor_down, door_open
    );

    modport slave (
        input  x, floor_key,
        output e, c, u, l, motor_up, motor_down, door_open
    );
endinterface

// File: rtl/elevator_state_sequencer.sv
// Registered state stage of the elevator controller: state, door timer,
// current/target floor and the actuator commands derived from them.
module elevator_state_sequencer #(
    parameter int TICK_DIV    = 8,
    parameter int MOVE_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    elevator_state_sequencer_if.slave   bus
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [MW-1:0] M_LAST = MW'(MOVE_CYCLES - 1);
    localparam logic [2:0]    C_FULL = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CLOSING = 2'b01,
        ST_MOVING  = 2'b10,
        ST_OPEN    = 2'b11
    } state_t;

    state_t        e_r, e_n_s;
    logic [2:0]    c_r, c_n_s;
    logic [1:0]    u_r, u_n_s;
    logic [1:0]    l_r, l_n_s;
    logic [PW-1:0] p_r, p_n_s;
    logic [MW-1:0] m_r, m_n_s;
    logic          motor_up_r, motor_down_r, door_open_r;
    logic          motor_up_n_s, motor_down_n_s, door_open_n_s;
    logic          tick_s;

    function automatic logic [1:0] lowest_key(input logic [3:0] k);
        logic [1:0] idx;
        casez (k)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    // Next-state logic for every register, including the actuator commands.
    always_comb begin
        e_n_s  = e_r;
        c_n_s  = c_r;
        u_n_s  = u_r;
        l_n_s  = l_r;
        p_n_s  = p_r;
        m_n_s  = m_r;
        tick_s = (p_r == P_LAST);

        if (e_r == ST_IDLE && bus.floor_key != 4'd0) begin
            l_n_s = lowest_key(bus.floor_key);
        end else begin
            l_n_s = l_r;
        end

        // An advance edge only performs the entry loads; ticks and steps are dropped.
        if (bus.x) begin
            e_n_s = state_t'(e_r + 2'd1);
            p_n_s = {PW{1'b0}};
            m_n_s = {MW{1'b0}};
            c_n_s = (e_r == ST_MOVING) ? C_FULL : 3'd0;
            u_n_s = u_r;
        end else begin
            p_n_s = tick_s ? {PW{1'b0}} : p_r + PW'(1);
            case (e_r)
                ST_CLOSING: begin
                    if (tick_s && c_r != C_FULL) c_n_s = c_r + 3'd1;
                    else                         c_n_s = c_r;
                end
                ST_OPEN: begin
                    if (tick_s && c_r != 3'd0) c_n_s = c_r - 3'd1;
                    else                       c_n_s = c_r;
                end
                default: c_n_s = 3'd0;
            endcase
            if (e_r == ST_MOVING && u_r != l_r) begin
                if (m_r == M_LAST) begin
                    m_n_s = {MW{1'b0}};
                    u_n_s = (l_r > u_r) ? u_r + 2'd1 : u_r - 2'd1;
                end else begin
                    m_n_s = m_r + MW'(1);
                    u_n_s = u_r;
                end
            end else begin
                m_n_s = {MW{1'b0}};
                u_n_s = u_r;
            end
        end

        // Outputs are registered from next-state values so they track the state in the same cycle.
        motor_up_n_s   = (e_n_s == ST_MOVING) && (l_n_s > u_n_s);
        motor_down_n_s = (e_n_s == ST_MOVING) && (l_n_s < u_n_s);
        door_open_n_s  = (e_n_s == ST_OPEN);
    end

    // State register bank with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_r          <= ST_IDLE;
            c_r          <= 3'd0;
            u_r          <= 2'd0;
            l_r          <= 2'd0;
            p_r          <= {PW{1'b0}};
            m_r          <= {MW{1'b0}};
            motor_up_r   <= 1'b0;
            motor_down_r <= 1'b0;
            door_open_r  <= 1'b0;
        end else begin
            e_r          <= e_n_s;
            c_r          <= c_n_s;
            u_r          <= u_n_s;
            l_r          <= l_n_s;
            p_r          <= p_n_s;
            m_r          <= m_n_s;
            motor_up_r   <= motor_up_n_s;
            motor_down_r <= motor_down_n_s;
            door_open_r  <= door_open_n_s;
        end
    end

    assign bus.e          = e_r;
    assign bus.c          = c_r;
    assign bus.u          = u_r;
    assign bus.l          = l_r;
    assign bus.motor_up   = motor_up_r;
    assign bus.motor_down = motor_down_r;
    assign bus.door_open  = door_open_r;

endmodule

// File: tb/tb_elevator_state_sequencer.sv
// Directed scoreboard bench for elevator_state_sequencer (TICK_DIV=2, MOVE_CYCLES=4).
module tb_elevator_state_sequencer;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    elevator_state_sequencer_if bus ();

    elevator_state_sequencer #(
        .TICK_DIV    (2),
        .MOVE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t item;
        item.tag = tag;
        item.val = val;
        sb.push_back(item);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t item;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty observed=%0d", obs);
        end else begin
            item = sb.pop_front();
            assert (obs === item.val) else begin
                failures++;
                $error("FAIL %s observed=%0d expected=%0d", item.tag, obs, item.val);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.x         = 1'b0;
        bus.floor_key = 4'b0000;

        // Power-on reset state
        push("rst_e", 0); push("rst_c", 0); push("rst_u", 0); push("rst_l", 0);
        cyc(2);
        chk(bus.e); chk(bus.c); chk(bus.u); chk(bus.l);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);

        // Target latch in IDLE
        bus.floor_key = 4'b1100;
        push("latch_l", 2); push("latch_e", 0);
        cyc(1);
        chk(bus.l); chk(bus.e);
        bus.floor_key = 4'b0000;
        push("latch_hold_l", 2);
        cyc(1);
        chk(bus.l);

        // Enter CLOSING
        bus.x = 1'b1;
        push("closing_e", 1); push("closing_c0", 0);
        cyc(1);
        bus.x = 1'b0;
        chk(bus.e); chk(bus.c);
        bus.floor_key = 4'b0001;
        push("closing_l_hold", 2); push("closing_c1", 0);
        cyc(1);
        chk(bus.l); chk(bus.c);
        bus.floor_key = 4'b0000;
        for (int k = 2; k <= 15; k++) begin
            push($sformatf("closing_c_k%0d", k), ((k / 2) > 5) ? 5 : (k / 2));
            cyc(1);
            chk(bus.c);
        end

        // Collision: advance while a tick is due (p=1 after odd cycle count)
        bus.x = 1'b1;
        push("coll_e", 2); push("coll_c", 0); push("coll_p", 0); push("coll_motor_up", 1);
        cyc(1);
        bus.x = 1'b0;
        chk(bus.e); chk(bus.c); chk(32'(dut.p_r)); chk(bus.motor_up);
        for (int k = 1; k <= 4; k++) begin
            push($sformatf("coll_travel_u_k%0d", k), k / 4);
            cyc(1);
            chk(bus.u);
        end

        // Asynchronous reset mid-travel
        push("arst_motor_up", 0); push("arst_e", 0); push("arst_u", 0);
        push("arst_l", 0); push("arst_c", 0); push("arst_door", 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk(bus.motor_up); chk(bus.e); chk(bus.u); chk(bus.l); chk(bus.c); chk(bus.door_open);
        @(negedge clk);
        rst_n = 1'b1;
        push("rel_e", 0); push("rel_u", 0); push("rel_l", 0);
        cyc(1);
        chk(bus.e); chk(bus.u); chk(bus.l);

        // Travel 0 -> 3
        bus.floor_key = 4'b1000;
        push("travel_l", 3);
        cyc(1);
        chk(bus.l);
        bus.floor_key = 4'b0000;
        bus.x = 1'b1;
        push("travel_e1", 1);
        cyc(1);
        chk(bus.e);
        push("travel_e2", 2); push("travel_up0", 1);
        cyc(1);
        bus.x = 1'b0;
        chk(bus.e); chk(bus.motor_up);
        for (int k = 1; k <= 14; k++) begin
            push($sformatf("travel_u_k%0d", k), ((k / 4) > 3) ? 3 : (k / 4));
            push($sformatf("travel_up_k%0d", k), (k < 12) ? 1 : 0);
            cyc(1);
            chk(bus.u); chk(bus.motor_up);
        end

        // Open timer
        bus.x = 1'b1;
        push("open_e", 3); push("open_c", 5); push("open_door", 1);
        cyc(1);
        bus.x = 1'b0;
        chk(bus.e); chk(bus.c); chk(bus.door_open);
        for (int k = 1; k <= 13; k++) begin
            push($sformatf("open_c_k%0d", k), ((5 - k / 2) < 0) ? 0 : (5 - k / 2));
            cyc(1);
            chk(bus.c);
        end
        bus.x = 1'b1;
        push("idle_e", 0); push("idle_door", 0); push("idle_c", 0);
        cyc(1);
        bus.x = 1'b0;
        chk(bus.e); chk(bus.door_open); chk(bus.c);

        // Lowest key wins, then travel downward
        bus.floor_key = 4'b1010;
        push("lowest_l", 1);
        cyc(1);
        chk(bus.l);
        bus.floor_key = 4'b0000;
        bus.x = 1'b1;
        cyc(1);
        push("down_e", 2); push("down_md", 1); push("down_mu", 0);
        cyc(1);
        bus.x = 1'b0;
        chk(bus.e); chk(bus.motor_down); chk(bus.motor_up);
        push("down_u", 2); push("down_md2", 1);
        cyc(4);
        chk(bus.u); chk(bus.motor_down);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
